// File: rtl/mmx_pkg.sv
// rtl/mmx_pkg.sv - shared defaults, source encodings and writeback record for the MMX writeback path
package mmx_pkg;

    // Default widths of the MMX writeback path
    localparam int MMX_DATA_W = 64;
    localparam int MMX_REG_W  = 3;

    // Writeback source encodings, as seen on grant_src
    localparam logic SRC_ALU  = 1'b0;
    localparam logic SRC_LOAD = 1'b1;

    // One writeback at the default widths: destination register, result data, producing pipe
    typedef struct packed {
        logic [MMX_REG_W-1:0]  rd;
        logic [MMX_DATA_W-1:0] data;
        logic                  src;
    } wb_rec_t;

    // Pack a writeback record from its fields
    function automatic wb_rec_t make_wb_rec(input logic [MMX_REG_W-1:0]  rd,
                                            input logic [MMX_DATA_W-1:0] data,
                                            input logic                  src);
        wb_rec_t rec;
        rec.rd   = rd;
        rec.data = data;
        rec.src  = src;
        return rec;
    endfunction

endpackage

// File: rtl/mmx_rr_pick.sv
// rtl/mmx_rr_pick.sv - two-input picker returning a one-hot grant, pointer breaks ties
module mmx_rr_pick (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    // A lone requester always wins; when both ask, the pointer names the winner
    always_comb begin
        grant_o    = 2'b00;
        grant_o[0] = valid0_i && (!valid1_i || (ptr_i == 1'b0));
        grant_o[1] = valid1_i && (!valid0_i || (ptr_i == 1'b1));
    end

endmodule

// File: rtl/mmx_wb_arbiter.sv
// rtl/mmx_wb_arbiter.sv - two-pipe MMX writeback arbiter with one output holding register (MMX_WB_RR_EN selects round-robin)
module mmx_wb_arbiter
    import mmx_pkg::*;
#(
    parameter int DATA_W = MMX_DATA_W,
    parameter int REG_W  = MMX_REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [REG_W-1:0]  req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [REG_W-1:0]  req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wb_ready,
    output logic              write_enable,
    output logic [REG_W-1:0]  write_select,
    output logic [DATA_W-1:0] write_data,
    output logic              grant_src
);

    // Held writeback: same layout as wb_rec_t plus a valid bit, at the configured widths
    typedef struct packed {
        logic              en;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              src;
    } hold_t;

    hold_t      hold_q, hold_d;
    logic       ptr;
    logic [1:0] grant;
    logic       slot_free;
    logic       accept;
    logic       contested;

`ifdef MMX_WB_RR_EN
    logic ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    // Fixed priority: the load pipe takes every contested cycle
    assign ptr = SRC_LOAD;
`endif

    mmx_rr_pick u_pick (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .ptr_i    (ptr),
        .grant_o  (grant)
    );

    // The slot can take a new writeback when empty or draining this cycle
    assign slot_free  = !hold_q.en || wb_ready;
    assign contested  = req0_valid && req1_valid;

    // Readies are gated by reset so nothing is accepted while the flops are cleared
    assign req0_ready = reset && slot_free && grant[0];
    assign req1_ready = reset && slot_free && grant[1];
    assign accept     = req0_ready || req1_ready;

    // Next held writeback: load on accept (drain and refill share a cycle), clear on a bare drain
    always_comb begin
        hold_d = hold_q;
        if (accept) begin
            hold_d.en   = 1'b1;
            hold_d.src  = req1_ready ? SRC_LOAD : SRC_ALU;
            hold_d.rd   = req1_ready ? req1_reg  : req0_reg;
            hold_d.data = req1_ready ? req1_data : req0_data;
        end else if (wb_ready) begin
            hold_d.en   = 1'b0;
        end
    end

    // Output holding register, cleared immediately by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

`ifdef MMX_WB_RR_EN
    // After a contested accept the pointer moves to the pipe that lost
    always_comb begin
        ptr_d = ptr_q;
        if (accept && contested) begin
            ptr_d = req1_ready ? SRC_ALU : SRC_LOAD;
        end
    end

    // Pointer register, ALU preferred out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= SRC_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_contested;
    assign unused_contested = contested;
`endif

    assign write_enable = hold_q.en;
    assign write_select = hold_q.rd;
    assign write_data   = hold_q.data;
    assign grant_src    = hold_q.src;

endmodule

// File: tb/tb_mmx_wb_arbiter.sv
// tb/tb_mmx_wb_arbiter.sv - directed and randomized self-checking bench for mmx_wb_arbiter
module tb_mmx_wb_arbiter;

    localparam int DW = 64;
    localparam int RW = 3;
`ifdef MMX_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [RW-1:0] req0_reg, req1_reg;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          wb_ready;
    logic          write_enable;
    logic [RW-1:0] write_select;
    logic [DW-1:0] write_data;
    logic          grant_src;

    int tests = 0;
    int fails = 0;

    // Reference model: the held writeback and the tie-break pointer
    logic          m_en, m_src, m_ptr;
    logic [RW-1:0] m_reg;
    logic [DW-1:0] m_data;
    logic          e_r0, e_r1;

    always #5 clk = ~clk;

    mmx_wb_arbiter #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_reg     (req0_reg),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_reg     (req1_reg),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .wb_ready     (wb_ready),
        .write_enable (write_enable),
        .write_select (write_select),
        .write_data   (write_data),
        .grant_src    (grant_src)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic void model_reset();
        m_en = 1'b0; m_src = 1'b0; m_ptr = 1'b0; m_reg = '0; m_data = '0;
    endfunction

    // Who should be granted this cycle, from the current inputs and model state
    function automatic void model_predict();
        logic sf, win;
        sf = !m_en || wb_ready;
        if (req0_valid && req1_valid) win = RR ? m_ptr : 1'b1;
        else                          win = req1_valid;
        e_r0 = sf && req0_valid && !win;
        e_r1 = sf && req1_valid && win;
    endfunction

    // Clock-edge update of the model
    function automatic void model_commit();
        if (e_r0 || e_r1) begin
            m_en   = 1'b1;
            m_src  = e_r1;
            m_reg  = e_r1 ? req1_reg : req0_reg;
            m_data = e_r1 ? req1_data : req0_data;
            if (RR && req0_valid && req1_valid) m_ptr = e_r0;
        end else if (wb_ready) begin
            m_en = 1'b0;
        end
    endfunction

    // One cycle: check readies, clock, check held outputs
    task automatic step(input string tag);
        model_predict();
        #1;
        check({tag, ".r0"}, 64'(req0_ready), 64'(e_r0));
        check({tag, ".r1"}, 64'(req1_ready), 64'(e_r1));
        model_commit();
        @(posedge clk);
        #1;
        check({tag, ".we"},  64'(write_enable), 64'(m_en));
        check({tag, ".sel"}, 64'(write_select), 64'(m_reg));
        check({tag, ".dat"}, write_data, m_data);
        check({tag, ".src"}, 64'(grant_src), 64'(m_src));
    endtask

    initial begin
        logic pend0, pend1;
        reset = 1'b0;
        req0_valid = 1'b1; req0_reg = '0; req0_data = '0;
        req1_valid = 1'b1; req1_reg = '0; req1_data = '0;
        wb_ready = 1'b1;
        model_reset();

        // Reset state, with both requesters asking
        repeat (2) @(posedge clk);
        #1;
        check("rst.we",  64'(write_enable), 64'd0);
        check("rst.sel", 64'(write_select), 64'd0);
        check("rst.dat", write_data, 64'd0);
        check("rst.src", 64'(grant_src), 64'd0);
        check("rst.r0",  64'(req0_ready), 64'd0);
        check("rst.r1",  64'(req1_ready), 64'd0);

        // ALU alone, accepted in the first cycle after reset release
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1; req0_reg = 3'd3; req0_data = 64'h1111;
        req1_valid = 1'b0;
        wb_ready = 1'b1;
        #1;
        check("alu.ready", 64'(req0_ready), 64'd1);
        step("alu");
        check("alu.we_k",  64'(write_enable), 64'd1);
        check("alu.sel_k", 64'(write_select), 64'd3);
        check("alu.dat_k", write_data, 64'h1111);
        check("alu.src_k", 64'(grant_src), 64'd0);

        // Four contested cycles
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_reg = 3'd1; req0_data = 64'hA0 + 64'(i);
            req1_valid = 1'b1; req1_reg = 3'd2; req1_data = 64'hB0 + 64'(i);
            wb_ready = 1'b1;
            #1;
            check("cont.r0_k", 64'(req0_ready), RR ? 64'(!i[0]) : 64'd0);
            step("cont");
            check("cont.we_k",  64'(write_enable), 64'd1);
            check("cont.src_k", 64'(grant_src), RR ? 64'(i[0]) : 64'd1);
        end

        // Stall: output frozen, readies low
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.r0_k", 64'(req0_ready), 64'd0);
            check("stall.r1_k", 64'(req1_ready), 64'd0);
            step("stall");
            check("stall.sel_k", 64'(write_select), 64'd2);
            check("stall.dat_k", write_data, 64'hB3);
            check("stall.src_k", 64'(grant_src), 64'd1);
        end
        wb_ready = 1'b1;
        step("release");
        check("release.we_k",  64'(write_enable), 64'd1);
        check("release.src_k", 64'(grant_src), RR ? 64'd0 : 64'd1);

        // Same destination register from both pipes
        req0_reg = 3'd5; req0_data = 64'hA;
        req1_reg = 3'd5; req1_data = 64'hB;
        step("same1");
        check("same1.sel_k", 64'(write_select), 64'd5);
        check("same1.dat_k", write_data, 64'hB);
        req1_valid = 1'b0;
        step("same2");
        check("same2.sel_k", 64'(write_select), 64'd5);
        check("same2.dat_k", write_data, 64'hA);
        check("same2.we_k",  64'(write_enable), 64'd1);

        // Asynchronous reset while a writeback is held
        req0_valid = 1'b1; req1_valid = 1'b1; wb_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst.we_k", 64'(write_enable), 64'd0);
        check("arst.r0_k", 64'(req0_ready), 64'd0);
        check("arst.r1_k", 64'(req1_ready), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        wb_ready = 1'b1;
        req0_data = 64'hC0; req1_data = 64'hD0;
        #1;
        check("arst.first_k", 64'(req0_ready), RR ? 64'd1 : 64'd0);
        step("arst");

        // Randomized traffic; a waiting requester keeps its reg and data
        pend0 = 1'b0; pend1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_reg   = 3'($urandom);
                req0_data  = {$urandom(), $urandom()};
            end
            if (!pend1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_reg   = 3'($urandom);
                req1_data  = {$urandom(), $urandom()};
            end
            wb_ready = ($urandom_range(0, 3) != 0);
            step("rnd");
            pend0 = req0_valid && !e_r0;
            pend1 = req1_valid && !e_r1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmx_wb_arbiter.md
MMX_WB_ARBITER -- requirements
Module: mmx_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 64: writeback data width in bits.
REQ-002 Parameter REG_W, default 3: MMX register index width in bits.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port req0_valid, input, 1: ALU pipe has a writeback pending.
REQ-006 Port req0_reg, input, REG_W: ALU destination register.
REQ-007 Port req0_data, input, DATA_W: ALU result.
REQ-008 Port req0_ready, output, 1: ALU writeback accepted this cycle when it is high together with req0_valid.
REQ-009 Ports req1_valid, req1_reg, req1_data and req1_ready: same as the req0 ports, for the load pipe.
REQ-010 Port wb_ready, input, 1: the register file can accept the held writeback this cycle.
REQ-011 Port write_enable, output, 1: a writeback is held on the output; this drives the register file and the stall scoreboard.
REQ-012 Port write_select, output, REG_W: register index of the held writeback.
REQ-013 Port write_data, output, DATA_W: data of the held writeback.
REQ-014 Port grant_src, output, 1: requester that produced the held writeback (0 = ALU, 1 = load).

Function
REQ-015 The block SHALL hold one writeback in an output register; write_enable, write_select, write_data and grant_src are driven only from that register.
REQ-016 slot_free = !write_enable || wb_ready; an accept can happen only when slot_free is high.
REQ-017 If exactly one reqN_valid is high and slot_free is high, reqN_ready SHALL be high in the same cycle (combinational).
REQ-018 If both requesters are valid and slot_free is high, exactly one ready SHALL be high, chosen by the priority pointer.
REQ-019 The winner is the requester named by the pointer; otherwise it is the other one.
REQ-020 Accepted reg, data and source SHALL appear on the outputs the next cycle, with write_enable high (latency 1).
REQ-021 When write_enable is high and wb_ready is high with no new accept, write_enable SHALL drop the next cycle.
REQ-022 When write_enable is high and wb_ready is low, all output registers SHALL hold and both readies SHALL be low.
REQ-023 A drain (wb_ready high) and an accept in the same cycle SHALL replace the register contents with no bubble.
REQ-024 After each contested accept, the pointer SHALL move to the requester that lost; an uncontested accept SHALL leave it unchanged.
REQ-025 Two requests for the same register index in the same cycle get no special handling: they are arbitrated normally and the loser writes in a later cycle.
REQ-026 A requester SHALL keep reg and data stable while valid is high and ready is low; the block does not check this.

Reset
REQ-027 While reset is low: write_enable = 0, write_select = 0, write_data = 0, grant_src = 0, pointer = 0 (ALU preferred), both readies = 0.
REQ-028 Reset asserted mid-transfer SHALL drop any held writeback immediately, without completing it.
REQ-029 The first accept is possible in the first cycle after reset deasserts.

Configuration
REQ-030 Macro MMX_WB_RR_EN defined: round-robin pointer as in REQ-024.
REQ-031 Macro MMX_WB_RR_EN undefined: fixed priority; the load pipe (req1) always wins a contested cycle and the pointer register is not built.

Structure
REQ-032 A shared package mmx_pkg SHALL hold the DATA_W/REG_W defaults, the source encodings SRC_ALU = 0 and SRC_LOAD = 1, and the writeback record type (reg, data, src).
REQ-033 The block SHALL have one sub-module, mmx_rr_pick: a two-input picker that takes both valids and the pointer and returns a one-hot grant.

Verification
REQ-034 ALU only, req0_reg = 3, data = 0x1111, wb_ready = 1 -> req0_ready = 1 that cycle; next cycle write_enable = 1, write_select = 3, write_data = 0x1111, grant_src = 0.
REQ-035 Both valid for 4 cycles, wb_ready = 1, round-robin built -> grants go ALU, load, ALU, load, with write_enable high every cycle.
REQ-036 Same as REQ-035 without MMX_WB_RR_EN -> load wins all 4 cycles and req0_ready stays 0.
REQ-037 Writeback held, wb_ready = 0 for 3 cycles with both requesters valid -> outputs frozen and both readies 0; wb_ready = 1 -> one drain and one accept in the same cycle.
REQ-038 Both requesters target register 5 (data 0xA, 0xB) -> two write cycles in a row, both with write_select = 5, in pointer order.
REQ-039 Reset pulled low while write_enable = 1 -> write_enable = 0 at once (asynchronously); after release the ALU wins the first contested cycle.
